// File: rtl/float_add_pipe_if.sv
// Operand/result handshake bundle for float_add_pipe.
// The master drives the operands and out_ready; the slave is the adder.
interface float_add_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] floatA;
  logic [W-1:0] floatB;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;

  modport master (
    output in_valid, floatA, floatB, sub, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, floatA, floatB, sub, out_ready,
    output in_ready, out_valid, sum
  );
endinterface

// File: rtl/float_add_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round/pack).
// Define FLOAT_ADD_PIPE_RNE_EN for round-to-nearest-even; otherwise results truncate.
module float_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic             clk,
  input logic             reset,
  float_add_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int AW   = MAN_W + 4;   // hidden + mantissa + guard/round/sticky
  localparam int NW   = MAN_W + 5;   // AW plus carry-out
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic s1_v, s2_v, s3_v;
  logic adv1, adv2, adv3;

  assign adv3 = !s3_v || bus.out_ready;
  assign adv2 = !s2_v || adv3;
  assign adv1 = !s1_v || adv2;
  assign bus.in_ready = !reset && adv1;

  // ---------------- stage 1: classify and align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             za, zb, ia, ib, a_big;

  assign sa = bus.floatA[W-1];
  assign ea = bus.floatA[W-2 -: EXP_W];
  assign ma = bus.floatA[MAN_W-1:0];
  assign sb = bus.floatB[W-1] ^ bus.sub;
  assign eb = bus.floatB[W-2 -: EXP_W];
  assign mb = bus.floatB[MAN_W-1:0];

  assign za    = (ea == '0);
  assign zb    = (eb == '0);
  assign ia    = (ea == EXP_ONES);
  assign ib    = (eb == EXP_ONES);
  assign a_big = ({ea, ma} >= {eb, mb});

  logic         c1_special;
  logic [W-1:0] c1_spec;

  always_comb begin
    c1_special = 1'b1;
    c1_spec    = '0;
    if (ia && ib)
      c1_spec = {(sa & sb), EXP_ONES, {MAN_W{1'b0}}};
    else if (ia)
      c1_spec = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (ib)
      c1_spec = {sb, EXP_ONES, {MAN_W{1'b0}}};
    else if (za && zb)
      c1_spec = '0;
    else if (za)
      c1_spec = {sb, eb, mb};
    else if (zb)
      c1_spec = {sa, ea, ma};
    else
      c1_special = 1'b0;
  end

  logic [EXP_W-1:0] big_exp, small_exp;
  logic [AW-1:0]    big_frac, small_frac, aligned, lost;
  logic [31:0]      diff;

  always_comb begin
    big_exp    = a_big ? ea : eb;
    small_exp  = a_big ? eb : ea;
    big_frac   = {1'b1, (a_big ? ma : mb), 3'b000};
    small_frac = {1'b1, (a_big ? mb : ma), 3'b000};
    diff       = 32'(big_exp) - 32'(small_exp);
    lost       = '0;
    // Beyond MAN_W+2 places the whole smaller fraction collapses into sticky.
    if (diff >= 32'(AW - 1)) begin
      aligned = {{(AW-1){1'b0}}, 1'b1};
    end else begin
      aligned    = small_frac >> diff;
      lost       = small_frac & ~({AW{1'b1}} << diff);
      aligned[0] = aligned[0] | (|lost);
    end
  end

  logic             s1_special, s1_sign, s1_sub;
  logic [W-1:0]     s1_spec;
  logic [EXP_W-1:0] s1_exp;
  logic [AW-1:0]    s1_big, s1_small;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
    end else if (adv1) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_special <= c1_special;
        s1_spec    <= c1_spec;
        s1_sign    <= a_big ? sa : sb;
        s1_sub     <= sa ^ sb;
        s1_exp     <= big_exp;
        s1_big     <= big_frac;
        s1_small   <= aligned;
      end
    end
  end

  // ---------------- stage 2: add / subtract ----------------
  logic [NW-1:0] c2_mag;

  // Larger magnitude is always the minuend, so the difference is non-negative.
  assign c2_mag = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                         : ({1'b0, s1_big} + {1'b0, s1_small});

  logic             s2_special, s2_sign;
  logic [W-1:0]     s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [NW-1:0]    s2_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v <= 1'b0;
    end else if (adv2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_special <= s1_special;
        s2_spec    <= s1_spec;
        s2_sign    <= s1_sign;
        s2_exp     <= s1_exp;
        s2_mag     <= c2_mag;
      end
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  int             lead_pos, shl, e_n, e_r;
  logic [NW-1:0]  norm;
  logic           lead_bit, inc;
  logic [MAN_W-1:0] man_t;
  logic [3:0]     grs;
  logic [MAN_W:0] man_r;
  logic [W-1:0]   c3_res;

  always_comb begin
    lead_pos = 0;
    for (int i = 0; i < NW; i++)
      if (s2_mag[i]) lead_pos = i;
    shl  = NW - 1 - lead_pos;
    norm = s2_mag << shl;
    {lead_bit, man_t, grs} = norm;
    e_n = int'(s2_exp) + 1 - shl;
`ifdef FLOAT_ADD_PIPE_RNE_EN
    inc = grs[3] & (grs[2] | (|grs[1:0]) | man_t[0]);
`else
    inc = 1'b0;
`endif
    man_r = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
    // All-ones mantissa rounding up wraps to zero with one more exponent.
    e_r = e_n + int'(man_r[MAN_W]);

    if (s2_special)
      c3_res = s2_spec;
    else if (!lead_bit)
      c3_res = '0;
    else if (e_n <= 0)
      c3_res = {s2_sign, {(W-1){1'b0}}};
    else if (e_r >= EMAX)
      c3_res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    else
      c3_res = {s2_sign, e_r[EXP_W-1:0], man_r[MAN_W-1:0]};
  end

`ifndef FLOAT_ADD_PIPE_RNE_EN
  logic unused_grs;
  assign unused_grs = ^grs;
`endif

  logic [W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_v  <= 1'b0;
      sum_q <= '0;
    end else if (adv3) begin
      s3_v <= s2_v;
      if (s2_v) sum_q <= c3_res;
    end
  end

  assign bus.out_valid = s3_v;
  assign bus.sum       = sum_q;
endmodule

// File: tb/tb_float_add_pipe.sv
// Directed bench for float_add_pipe at fp16 defaults: arithmetic corners,
// streaming with a stalled consumer, and reset with results in flight.
module tb_float_add_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef FLOAT_ADD_PIPE_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  localparam logic [15:0] ST_A [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                       16'h4500, 16'h4600, 16'h4700, 16'h4800};
  localparam logic [15:0] ST_S [8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                       16'h4600, 16'h4700, 16'h4800, 16'h4880};

  float_add_pipe_if #(.EXP_W(5), .MAN_W(10)) bus ();

  float_add_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with an empty pipeline; returns at a falling edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] exp_sum);
    int lat;
    bus.floatA    = a;
    bus.floatB    = b;
    bus.sub       = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
    @(negedge clk);
  endtask

  initial begin
    int          idx_in, idx_out, stale;
    logic        stalled, in_fire;
    logic [15:0] held;

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.floatA    = 16'h3C00;
    bus.floatB    = 16'h3C00;
    bus.sub       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset sum", 32'(bus.sum), 32'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    run_op("1+2",          16'h3C00, 16'h4000, 1'b0, 16'h4200);
    run_op("1-1",          16'h3C00, 16'h3C00, 1'b1, 16'h0000);
    run_op("underflow",    16'h0600, 16'h8400, 1'b0, 16'h0000);
    run_op("overflow+",    16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);
    run_op("overflow-",    16'hFBFF, 16'hFBFF, 1'b0, 16'hFC00);
    run_op("round up",     16'h3C00, 16'h1200, 1'b0, RNE ? 16'h3C01 : 16'h3C00);
    run_op("tie even",     16'h3C00, 16'h1000, 1'b0, 16'h3C00);
    run_op("zero+b",       16'h0000, 16'hC500, 1'b0, 16'hC500);
    run_op("zero-b",       16'h0000, 16'h4500, 1'b1, 16'hC500);
    run_op("-0+-0",        16'h8000, 16'h8000, 1'b0, 16'h0000);
    run_op("inf+1",        16'h7C00, 16'h3C00, 1'b0, 16'h7C00);
    run_op("inf-inf",      16'h7C00, 16'h7C00, 1'b1, 16'h7C00);
    run_op("-inf+1",       16'hFC00, 16'h3C00, 1'b0, 16'hFC00);
    run_op("nan in",       16'h7E00, 16'h0000, 1'b0, 16'h7C00);
    run_op("1-2 sign",     16'h3C00, 16'h4000, 1'b1, 16'hBC00);
    run_op("cancel",       16'h4000, 16'h3FFF, 1'b1, 16'h1400);
    run_op("sticky add",   16'h3C00, 16'h0400, 1'b0, 16'h3C00);
    run_op("sticky sub",   16'h3C00, 16'h0400, 1'b1, RNE ? 16'h3C00 : 16'h3BFF);
    run_op("round ovf",    16'h7BFF, 16'h4C00, 1'b0, RNE ? 16'h7C00 : 16'h7BFF);

    // Eight back-to-back pairs with the consumer stalled in cycles 4..6.
    idx_in  = 0;
    idx_out = 0;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 24; c++) begin
      bus.out_ready = !(c >= 4 && c <= 6);
      bus.in_valid  = (idx_in < 8);
      bus.floatA    = ST_A[3'(idx_in)];
      bus.floatB    = 16'h3C00;
      bus.sub       = 1'b0;
      #1;
      if (c <= 10)
        chk($sformatf("stream in_ready c%0d", c), 32'(bus.in_ready), 32'(c < 4 || c > 6));
      if (stalled) begin
        chk($sformatf("stall valid c%0d", c), 32'(bus.out_valid), 32'd1);
        chk($sformatf("stall sum c%0d", c), 32'(bus.sum), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (idx_out < 8)
          chk($sformatf("stream out %0d", idx_out), 32'(bus.sum), 32'(ST_S[3'(idx_out)]));
        idx_out++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.sum;
      in_fire = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (in_fire) idx_in++;
    end
    bus.in_valid = 1'b0;
    chk("stream inputs taken", idx_in, 8);
    chk("stream outputs seen", idx_out, 8);

    // Two results in flight, then a one-cycle reset pulse.
    bus.out_ready = 1'b1;
    bus.floatA    = 16'h3C00;
    bus.floatB    = 16'h3C00;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.floatA = 16'h4000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    chk("mid reset in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("after reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("after reset sum", 32'(bus.sum), 32'd0);
    run_op("post reset", 16'h4400, 16'h3C00, 1'b0, 16'h4500);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) stale++;
      @(negedge clk);
    end
    chk("no stale results", stale, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
